// File: rtl/wb_redirect_unit_if.sv
// wb_redirect_unit_if
//   Bundles the EX/WB pipeline-register outputs that feed the write-back /
//   redirect stage, together with that stage's register-file, PC-load,
//   flush and retire-count results.
//   modport master : the pipeline side. It drives the EX/WB beat and observes
//                    the results.
//   modport slave  : the write-back / redirect stage.
interface wb_redirect_unit_if;
    // EX/WB beat
    logic        validIn;
    logic        NIn;
    logic        ZIn;
    logic        memToRegIn;
    logic        RegWrtIn;
    logic        BranchZIn;
    logic        BranchNIn;
    logic        JumpIn;
    logic        JumpMemIn;
    logic [31:0] memOutIn;
    logic [31:0] ALUOutIn;
    logic [5:0]  rdIn;

    // register file / PC / pipeline control
    logic        regWrEn;
    logic [5:0]  regWrAddr;
    logic [31:0] regWrData;
    logic        pcLoad;
    logic [31:0] pcTarget;
    logic        flush;
    logic [31:0] retireCount;

    modport master (
        output validIn, NIn, ZIn, memToRegIn, RegWrtIn, BranchZIn, BranchNIn,
               JumpIn, JumpMemIn, memOutIn, ALUOutIn, rdIn,
        input  regWrEn, regWrAddr, regWrData, pcLoad, pcTarget, flush,
               retireCount
    );

    modport slave (
        input  validIn, NIn, ZIn, memToRegIn, RegWrtIn, BranchZIn, BranchNIn,
               JumpIn, JumpMemIn, memOutIn, ALUOutIn, rdIn,
        output regWrEn, regWrAddr, regWrData, pcLoad, pcTarget, flush,
               retireCount
    );
endinterface

// File: rtl/wb_redirect_unit.sv
// wb_redirect_unit
//   Write-back and control-redirect stage. Each accepted EX/WB beat becomes a
//   register-file write (ALU result or memory data). Taken branches and jumps
//   also become a PC load. A redirect holds flush high for FLUSH_DEPTH cycles
//   so the wrong-path slots upstream are discarded, and beats that arrive
//   during that window are squashed. Accepted beats are counted.
//   Ports:
//     clk  : clock; all state updates on the rising edge
//     rst  : synchronous, active-high reset
//     bus  : wb_redirect_unit_if.slave (EX/WB beat in; regWr*, pcLoad,
//            pcTarget, flush and retireCount out; all outputs registered)
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_RUN   | beats are accepted; flush low
//   ST_FLUSH | wrong-path beats are squashed; flush high; flush_cnt counts
//            | the remaining squash cycles down to 1
module wb_redirect_unit #(
    parameter int unsigned FLUSH_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    wb_redirect_unit_if.slave bus
);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    localparam logic [3:0] DEPTH = 4'(FLUSH_DEPTH);

    state_t      state_q, state_d;
    logic [3:0]  flush_cnt_q, flush_cnt_d;
    logic        accept;
    logic        taken;
    logic [31:0] target;
    logic [31:0] wr_data;

    logic        reg_wr_en;
    logic [5:0]  reg_wr_addr;
    logic [31:0] reg_wr_data;
    logic        pc_load;
    logic [31:0] pc_target;
    logic [31:0] retire_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            flush_cnt_q <= 4'd0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        accept      = 1'b0;
        taken       = bus.JumpIn | bus.JumpMemIn
                    | (bus.BranchZIn & bus.ZIn)
                    | (bus.BranchNIn & bus.NIn);
        // A memory-indirect jump wins over any other concurrent redirect.
        target      = bus.JumpMemIn  ? bus.memOutIn : bus.ALUOutIn;
        wr_data     = bus.memToRegIn ? bus.memOutIn : bus.ALUOutIn;
        case (state_q)
            ST_RUN: begin
                accept = bus.validIn;
                if (bus.validIn && taken) begin
                    state_d     = ST_FLUSH;
                    flush_cnt_d = DEPTH;
                end
            end
            ST_FLUSH: begin
                if (flush_cnt_q == 4'd1) begin
                    state_d     = ST_RUN;
                    flush_cnt_d = 4'd0;
                end else begin
                    flush_cnt_d = flush_cnt_q - 4'd1;
                end
            end
            default: begin
                state_d     = ST_RUN;
                flush_cnt_d = 4'd0;
            end
        endcase
    end

    // Address, data and target hold their last values on idle cycles. Only
    // the two strobes return to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            reg_wr_en   <= 1'b0;
            reg_wr_addr <= 6'd0;
            reg_wr_data <= 32'd0;
            pc_load     <= 1'b0;
            pc_target   <= 32'd0;
            retire_cnt  <= 32'd0;
        end else begin
            reg_wr_en <= 1'b0;
            pc_load   <= 1'b0;
            if (accept) begin
                // A taken beat still performs its own write (link register).
                reg_wr_en   <= bus.RegWrtIn;
                reg_wr_addr <= bus.rdIn;
                reg_wr_data <= wr_data;
                retire_cnt  <= retire_cnt + 32'd1;
                if (taken) begin
                    pc_load   <= 1'b1;
                    pc_target <= target;
                end
            end
        end
    end

    assign bus.regWrEn     = reg_wr_en;
    assign bus.regWrAddr   = reg_wr_addr;
    assign bus.regWrData   = reg_wr_data;
    assign bus.pcLoad      = pc_load;
    assign bus.pcTarget    = pc_target;
    assign bus.flush       = (state_q == ST_FLUSH);
    assign bus.retireCount = retire_cnt;

endmodule

// File: tb/tb_wb_redirect_unit.sv
module tb_wb_redirect_unit;
    localparam int FLUSH_DEPTH = 2;

    logic clk;
    logic rst;
    int   checks;
    int   passed;

    // Reference model: what the outputs must read after the most recent edge.
    logic        m_wen;
    logic [5:0]  m_addr;
    logic [31:0] m_data;
    logic        m_pcl;
    logic [31:0] m_tgt;
    logic [31:0] m_retire;
    int          squash_left;   // wrong-path slots still to discard

    wb_redirect_unit_if ifc ();

    wb_redirect_unit #(.FLUSH_DEPTH(FLUSH_DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        ifc.validIn    = 1'b0;
        ifc.NIn        = 1'b0;
        ifc.ZIn        = 1'b0;
        ifc.memToRegIn = 1'b0;
        ifc.RegWrtIn   = 1'b0;
        ifc.BranchZIn  = 1'b0;
        ifc.BranchNIn  = 1'b0;
        ifc.JumpIn     = 1'b0;
        ifc.JumpMemIn  = 1'b0;
        ifc.memOutIn   = 32'd0;
        ifc.ALUOutIn   = 32'd0;
        ifc.rdIn       = 6'd0;
    endtask

    task automatic random_inputs(input int redirect_pct);
        ifc.validIn    = ($urandom_range(99) < 80);
        ifc.NIn        = 1'($urandom);
        ifc.ZIn        = 1'($urandom);
        ifc.memToRegIn = 1'($urandom);
        ifc.RegWrtIn   = 1'($urandom);
        ifc.BranchZIn  = ($urandom_range(99) < redirect_pct);
        ifc.BranchNIn  = ($urandom_range(99) < redirect_pct);
        ifc.JumpIn     = ($urandom_range(99) < redirect_pct / 2);
        ifc.JumpMemIn  = ($urandom_range(99) < redirect_pct / 2);
        ifc.memOutIn   = $urandom;
        ifc.ALUOutIn   = $urandom;
        ifc.rdIn       = 6'($urandom);
    endtask

    // Apply one clock edge with the current inputs and advance the model.
    task automatic tick();
        logic redirect;
        redirect = ifc.JumpIn | ifc.JumpMemIn | (ifc.BranchZIn & ifc.ZIn)
                 | (ifc.BranchNIn & ifc.NIn);
        m_wen = 1'b0;
        m_pcl = 1'b0;
        if (rst) begin
            m_addr      = '0;
            m_data      = '0;
            m_tgt       = '0;
            m_retire    = '0;
            squash_left = 0;
        end else if (squash_left > 0) begin
            squash_left--;
        end else if (ifc.validIn) begin
            m_wen    = ifc.RegWrtIn;
            m_addr   = ifc.rdIn;
            m_data   = ifc.memToRegIn ? ifc.memOutIn : ifc.ALUOutIn;
            m_retire = m_retire + 32'd1;
            if (redirect) begin
                m_pcl       = 1'b1;
                m_tgt       = ifc.JumpMemIn ? ifc.memOutIn : ifc.ALUOutIn;
                squash_left = FLUSH_DEPTH;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            random_inputs(30);
            ifc.validIn = 1'b1;
            tick();
        end
        checks++;
        if ({ifc.regWrEn, ifc.regWrAddr, ifc.regWrData, ifc.pcLoad,
             ifc.pcTarget, ifc.flush} !== 72'd0)
            $display("FAIL reset_outputs: got wen=%b addr=%0d data=%h pcl=%b tgt=%h flush=%b, expected all 0",
                     ifc.regWrEn, ifc.regWrAddr, ifc.regWrData, ifc.pcLoad,
                     ifc.pcTarget, ifc.flush);
        else passed++;
        checks++;
        if (ifc.retireCount !== 32'd0)
            $display("FAIL reset_retire: got %h expected 0", ifc.retireCount);
        else passed++;
        rst = 1'b0;
        clear_inputs();
        tick();
    endtask

    task automatic test_alu_write();
        clear_inputs();
        ifc.validIn  = 1'b1;
        ifc.RegWrtIn = 1'b1;
        ifc.ALUOutIn = 32'h0000_1234;
        ifc.memOutIn = 32'hAAAA_5555;
        ifc.rdIn     = 6'd5;
        tick();
        clear_inputs();
        checks++;
        if ({ifc.regWrEn, ifc.regWrAddr, ifc.regWrData, ifc.pcLoad} !== {1'b1, 6'd5, 32'h1234, 1'b0})
            $display("FAIL alu_write: got wen=%b addr=%0d data=%h pcl=%b, expected 1/5/00001234/0",
                     ifc.regWrEn, ifc.regWrAddr, ifc.regWrData, ifc.pcLoad);
        else passed++;
        checks++;
        if (ifc.retireCount !== 32'd1)
            $display("FAIL alu_retire: got %0d expected 1", ifc.retireCount);
        else passed++;
        tick();
        checks++;
        if ({ifc.regWrEn, ifc.regWrAddr, ifc.regWrData} !== {1'b0, 6'd5, 32'h1234})
            $display("FAIL idle_hold: got wen=%b addr=%0d data=%h, expected 0/5/00001234",
                     ifc.regWrEn, ifc.regWrAddr, ifc.regWrData);
        else passed++;
    endtask

    task automatic test_mem_write();
        clear_inputs();
        ifc.validIn    = 1'b1;
        ifc.RegWrtIn   = 1'b1;
        ifc.memToRegIn = 1'b1;
        ifc.ALUOutIn   = 32'h0000_1234;
        ifc.memOutIn   = 32'hDEAD_BEEF;
        ifc.rdIn       = 6'd0;
        tick();
        clear_inputs();
        checks++;
        if ({ifc.regWrEn, ifc.regWrAddr, ifc.regWrData} !== {1'b1, 6'd0, 32'hDEAD_BEEF})
            $display("FAIL mem_write: got wen=%b addr=%0d data=%h, expected 1/0/deadbeef",
                     ifc.regWrEn, ifc.regWrAddr, ifc.regWrData);
        else passed++;
    endtask

    task automatic test_branch_z();
        logic [31:0] base;
        base = m_retire;
        clear_inputs();
        ifc.validIn   = 1'b1;
        ifc.BranchZIn = 1'b1;
        ifc.ZIn       = 1'b1;
        ifc.ALUOutIn  = 32'h40;
        tick();
        checks++;
        if ({ifc.pcLoad, ifc.pcTarget, ifc.flush} !== {1'b1, 32'h40, 1'b1})
            $display("FAIL bz_taken: got pcl=%b tgt=%h flush=%b, expected 1/00000040/1",
                     ifc.pcLoad, ifc.pcTarget, ifc.flush);
        else passed++;
        clear_inputs();
        ifc.validIn  = 1'b1;
        ifc.RegWrtIn = 1'b1;
        ifc.rdIn     = 6'd9;
        ifc.ALUOutIn = 32'h99;
        ifc.JumpIn   = 1'b1;
        for (int i = 0; i < FLUSH_DEPTH; i++) begin
            tick();
            checks++;
            if ({ifc.regWrEn, ifc.pcLoad, ifc.flush, ifc.retireCount} !==
                {1'b0, 1'b0, (i < FLUSH_DEPTH - 1), base + 32'd1})
                $display("FAIL bz_squash%0d: got wen=%b pcl=%b flush=%b retire=%0d, expected 0/0/%0b/%0d",
                         i, ifc.regWrEn, ifc.pcLoad, ifc.flush, ifc.retireCount,
                         (i < FLUSH_DEPTH - 1), base + 32'd1);
            else passed++;
        end
        ifc.JumpIn = 1'b0;
        tick();
        checks++;
        if ({ifc.regWrEn, ifc.regWrAddr, ifc.pcLoad, ifc.flush, ifc.retireCount} !==
            {1'b1, 6'd9, 1'b0, 1'b0, base + 32'd2})
            $display("FAIL bz_resume: got wen=%b addr=%0d pcl=%b flush=%b retire=%0d, expected 1/9/0/0/%0d",
                     ifc.regWrEn, ifc.regWrAddr, ifc.pcLoad, ifc.flush,
                     ifc.retireCount, base + 32'd2);
        else passed++;
        clear_inputs();
        ifc.validIn   = 1'b1;
        ifc.BranchZIn = 1'b1;
        ifc.ZIn       = 1'b0;
        ifc.NIn       = 1'b1;
        ifc.ALUOutIn  = 32'h80;
        tick();
        clear_inputs();
        checks++;
        if ({ifc.pcLoad, ifc.pcTarget, ifc.flush, ifc.retireCount} !==
            {1'b0, 32'h40, 1'b0, base + 32'd3})
            $display("FAIL bz_not_taken: got pcl=%b tgt=%h flush=%b retire=%0d, expected 0/00000040/0/%0d",
                     ifc.pcLoad, ifc.pcTarget, ifc.flush, ifc.retireCount, base + 32'd3);
        else passed++;
    endtask

    task automatic test_jump_mem();
        clear_inputs();
        ifc.validIn   = 1'b1;
        ifc.JumpMemIn = 1'b1;
        ifc.JumpIn    = 1'b1;
        ifc.memOutIn  = 32'h200;
        ifc.ALUOutIn  = 32'h300;
        tick();
        clear_inputs();
        checks++;
        if ({ifc.pcLoad, ifc.pcTarget} !== {1'b1, 32'h200})
            $display("FAIL jmem_target: got pcl=%b tgt=%h, expected 1/00000200",
                     ifc.pcLoad, ifc.pcTarget);
        else passed++;
        tick();
        checks++;
        if ({ifc.pcLoad, ifc.flush} !== 2'b01)
            $display("FAIL jmem_single: got pcl=%b flush=%b, expected 0/1",
                     ifc.pcLoad, ifc.flush);
        else passed++;
        for (int i = 0; i < FLUSH_DEPTH; i++) tick();
    endtask

    task automatic test_reset_mid_flush();
        clear_inputs();
        ifc.validIn  = 1'b1;
        ifc.JumpIn   = 1'b1;
        ifc.ALUOutIn = 32'h80;
        tick();
        checks++;
        if (ifc.flush !== 1'b1)
            $display("FAIL rmf_flush_on: got %b expected 1", ifc.flush);
        else passed++;
        rst = 1'b1;
        ifc.JumpIn   = 1'b0;
        ifc.RegWrtIn = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({ifc.flush, ifc.regWrEn, ifc.pcLoad, ifc.retireCount} !== 35'd0)
            $display("FAIL rmf_after_reset: got flush=%b wen=%b pcl=%b retire=%0d, expected all 0",
                     ifc.flush, ifc.regWrEn, ifc.pcLoad, ifc.retireCount);
        else passed++;
        ifc.rdIn = 6'd17;
        tick();
        clear_inputs();
        checks++;
        if ({ifc.regWrEn, ifc.regWrAddr, ifc.retireCount} !== {1'b1, 6'd17, 32'd1})
            $display("FAIL rmf_accept: got wen=%b addr=%0d retire=%0d, expected 1/17/1",
                     ifc.regWrEn, ifc.regWrAddr, ifc.retireCount);
        else passed++;
    endtask

    task automatic test_wrap();
        clear_inputs();
        force dut.retire_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.retire_cnt;
        m_retire = 32'hFFFF_FFFF;
        ifc.validIn = 1'b1;
        tick();
        clear_inputs();
        checks++;
        if (ifc.retireCount !== 32'd0)
            $display("FAIL retire_wrap: got %h expected 00000000", ifc.retireCount);
        else passed++;
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            random_inputs(n < 300 ? 20 : 5);
            rst = ($urandom_range(99) < 2);
            tick();
            checks++;
            if ({ifc.regWrEn, ifc.regWrAddr, ifc.regWrData, ifc.pcLoad, ifc.pcTarget,
                 ifc.flush, ifc.retireCount} !==
                {m_wen, m_addr, m_data, m_pcl, m_tgt, (squash_left > 0), m_retire})
                $display("FAIL random_%0d: got wen=%b addr=%0d data=%h pcl=%b tgt=%h flush=%b retire=%0d, expected wen=%b addr=%0d data=%h pcl=%b tgt=%h flush=%b retire=%0d",
                         n, ifc.regWrEn, ifc.regWrAddr, ifc.regWrData, ifc.pcLoad,
                         ifc.pcTarget, ifc.flush, ifc.retireCount, m_wen, m_addr,
                         m_data, m_pcl, m_tgt, (squash_left > 0), m_retire);
            else passed++;
        end
        rst = 1'b0;
        clear_inputs();
    endtask

    initial begin
        checks      = 0;
        passed      = 0;
        squash_left = 0;
        m_wen       = 1'b0;
        m_addr      = '0;
        m_data      = '0;
        m_pcl       = 1'b0;
        m_tgt       = '0;
        m_retire    = '0;
        rst         = 1'b1;
        clear_inputs();
        @(posedge clk);
        #1;
        test_reset();
        test_alu_write();
        test_mem_write();
        test_branch_z();
        test_jump_mem();
        test_reset_mid_flush();
        test_wrap();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
